// File: rtl/serial_word_serializer.sv
// Parallel-to-serial stage: one WIDTH-bit word per valid/ready handshake, emitted MSB-first on dout.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after every word.
module serial_word_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic             accept;
    logic             last_bit;

`ifdef SERIALIZER_PARITY_EN
    logic             parity_acc;
`endif

    assign last_bit = (bit_cnt == LAST_BIT);

    // Ready depends only on state and counter, so upstream never sees a loop through in_valid.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            SHIFT:   in_ready = 1'b0;
            PARITY:  in_ready = 1'b1;
`else
            SHIFT:   in_ready = last_bit;
`endif
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                next_state = accept ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (!last_bit) begin
                    next_state = SHIFT;
                end else begin
`ifdef SERIALIZER_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                next_state = accept ? SHIFT : IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Outputs come purely from registered state so no input reaches dout combinationally.
    always_comb begin
        dout_valid = 1'b0;
        dout       = 1'b0;
        case (state)
            SHIFT: begin
                dout_valid = 1'b1;
                dout       = shift_reg[WIDTH-1];
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                dout_valid = 1'b1;
                dout       = parity_acc;
            end
`endif
            default: begin
                dout_valid = 1'b0;
                dout       = 1'b0;
            end
        endcase
    end

    assign busy = dout_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The counter saturates at the last bit; an accept always restarts it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (accept) begin
            bit_cnt   <= '0;
            shift_reg <= in_data;
        end else if (state == SHIFT) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            if (!last_bit) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_acc <= 1'b0;
        end else if (accept) begin
            parity_acc <= 1'b0;
        end else if (state == SHIFT) begin
            parity_acc <= parity_acc ^ shift_reg[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_serial_word_serializer.sv
// Scoreboard bench for serial_word_serializer: the driver queues each accepted word's expected bits,
// and a negedge monitor pops and compares them against dout while also checking ready/valid.
module tb_serial_word_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;

    int testsRun = 0;
    int testsFailed = 0;
    bit expQ[$];

    always #5 clk = ~clk;

    serial_word_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a word becomes its bits MSB-first, plus even parity when configured.
    task automatic pushWord(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) expQ.push_back(w[i]);
`ifdef SERIALIZER_PARITY_EN
        expQ.push_back(^w);
`endif
    endtask

    // Monitor: at each negedge the queue holds every bit still owed, so its head is the current bit,
    // and the block should be ready exactly when nothing remains after that head.
    always @(negedge clk) begin
        if (rst_n) begin
            bit expValid;
            expValid = (expQ.size() > 0);
            checkOutput("dout_valid", dout_valid, expValid);
            checkOutput("busy", busy, expValid);
            if (expValid) begin
                bit b;
                b = expQ.pop_front();
                checkOutput("dout", dout, b);
            end else begin
                checkOutput("dout_idle", dout, 1'b0);
            end
            checkOutput("in_ready", in_ready, expQ.size() == 0);
        end
    end

    // Present a word, hold it until the model says it is accepted, then idle for gap cycles.
    task automatic applyStimulus(input logic [WIDTH-1:0] w, input int gap);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        in_data = w;
        in_valid = 1'b1;
        while (!done) begin
            @(posedge clk);
            if (expQ.size() == 0) begin
                pushWord(w);
                done = 1;
            end else if (++waited > 4 * WIDTH) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL accept_timeout: word %0h not accepted, expected within %0d cycles", w, 4 * WIDTH);
                done = 1;
            end
        end
        #1;
        if (gap > 0) begin
            in_valid = 1'b0;
            in_data = WIDTH'($urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 8 * WIDTH) begin
            @(posedge clk);
            waited++;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain_timeout: %0d bits left, expected 0", expQ.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        checkOutput("reset_dout", dout, 1'b0);
        checkOutput("reset_valid", dout_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("release_valid", dout_valid, 1'b0);
        checkOutput("release_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        applyStimulus(8'hA5, 1);
        drain();

        applyStimulus(8'hA5, 0);
        applyStimulus(8'h5A, 1);
        drain();

        `ifdef SERIALIZER_PARITY_EN
        applyStimulus(8'h07, 1);
        drain();
        `endif

        applyStimulus(8'hC3, 2);
        in_data = 8'hFF;
        applyStimulus(8'hFF, 1);
        drain();

        applyStimulus(8'hA5, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midreset_valid", dout_valid, 1'b0);
        checkOutput("midreset_ready", in_ready, 1'b1);
        checkOutput("midreset_dout", dout, 1'b0);
        checkOutput("midreset_busy", busy, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(8'h3C, 2);
        drain();

        for (int n = 0; n < 40; n++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            applyStimulus(WIDTH'($urandom), g);
        end
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/serial_word_serializer.md
# serial_word_serializer

Parallel-to-serial stage that feeds the serial bit stream consumed by the pattern-detector FSMs. It accepts one WIDTH-bit word per valid/ready handshake and emits it MSB-first, one bit per clock, on `dout` with a qualifying `dout_valid`. Words accepted back-to-back produce a gap-free bit stream. An optional even-parity bit can be appended after each word.

## Interface
- `WIDTH`, default 8: data word width in bits; legal range is ≥ 2.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_data`  input  WIDTH  parallel word to serialize; sampled only on accept.
- `in_valid`  input  1  upstream presents `in_data`.
- `in_ready`  output  1  block can accept a word this cycle; never depends on `in_valid`.
- `dout`  output  1  serial bit; 0 whenever `dout_valid` = 0.
- `dout_valid`  output  1  `dout` carries a live bit this cycle.
- `busy`  output  1  a word is being emitted; equals `dout_valid`.

## Operation
- Accept event: `in_valid` && `in_ready` at a rising edge. On accept:
  - `in_data` loads into a WIDTH-bit shift register.
  - The bit counter clears to 0.
  - State goes to SHIFT.
- States:
  - IDLE:
    - Outputs: `in_ready`=1, `dout_valid`=0, `dout`=0.
    - Transitions: accept → SHIFT; otherwise stay in IDLE.
  - SHIFT:
    - Outputs: `dout_valid`=1, `dout` = shift register MSB.
    - Each cycle: shift register shifts left by 1 (zero fill) and the counter increments.
    - `in_ready` = 1 only when counter = WIDTH-1 (last data bit); otherwise 0.
    - Transition at the last bit, without parity: accept → reload and stay in SHIFT (no idle cycle); no accept → IDLE.
    - Transition at the last bit, with parity: → PARITY. A word is never accepted during the last data bit in this mode, and `in_ready`=0 there.
  - PARITY (exists only when parity is configured):
    - Outputs: `dout_valid`=1, `dout` = XOR of all bits of the current word; `in_ready`=1.
    - Transitions: accept → SHIFT with the new word; otherwise → IDLE.
- Parity is accumulated as a running XOR of the emitted bits. The accumulator clears on every accept.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1; there is no wrap beyond that.
- Illegal state encoding → IDLE.
- `in_data` and `in_valid` are ignored while `in_ready`=0. Upstream must hold them until the accept.
- Reset mid-word: the word is discarded, with no partial or parity output. The block returns to IDLE.

## Timing
- Reset values:
  - Outputs: `dout`=0, `dout_valid`=0, `busy`=0, `in_ready`=1.
  - Internal: state IDLE, counter 0, shift register 0, parity 0.
- Latency: a word accepted at edge N puts its MSB on `dout` in the cycle following edge N. Bit k (0 = MSB) is valid in cycle N+1+k.
- Throughput:
  - Without parity: one word per WIDTH cycles, back-to-back.
  - With parity: one word per WIDTH+1 cycles.
- `dout`/`dout_valid` are decoded from registered state only. There is no combinational path from any input to `dout`/`dout_valid`.
- `in_ready` is decoded from state and counter only.

## Configuration
- Macro `SERIALIZER_PARITY_EN`:
  - Defined: the PARITY state and parity accumulator are compiled in, and every word is followed by one even-parity bit.
  - Undefined: no PARITY state and no accumulator logic. The last data bit offers `in_ready`=1 for zero-gap back-to-back streaming.

## Test plan
- Reset:
  - Assert `rst_n`=0 asynchronously between edges → `dout`=0, `dout_valid`=0, `busy`=0, `in_ready`=1 immediately.
  - These values are held through the release of `rst_n`.
- Single word, no parity:
  - Stimulus: `in_data`=8'hA5 with one-cycle `in_valid` in IDLE.
  - Response: `dout` = 1,0,1,0,0,1,0,1 over the next 8 cycles with `dout_valid`=1, then `dout_valid`=0 and `in_ready`=1.
- Back-to-back, no parity:
  - Stimulus: 8'hA5 then 8'h5A, with `in_valid` held high.
  - Response: second accept occurs on the last bit of 8'hA5; 16 consecutive `dout_valid`=1 cycles; stream 10100101_01011010.
- Backpressure:
  - Stimulus: change `in_data` to 8'hFF mid-word while `in_ready`=0.
  - Response: emitted word unchanged; 8'hFF is accepted only when `in_ready`=1.
- Parity build (`SERIALIZER_PARITY_EN`):
  - 8'hA5 → 9 valid bits ending in parity 0.
  - 8'h07 → 9 valid bits ending in parity 1.
  - Back-to-back words → exactly one parity cycle between them; `in_ready`=0 on the last data bit.
- Reset mid-word:
  - Stimulus: assert `rst_n`=0 after 3 bits of 8'hA5 have been emitted.
  - Response: `dout_valid`=0 and `in_ready`=1 immediately.
  - Check: next word 8'h3C after reset serializes as 00111100 with no leftover bits.
